// File: rtl/conv1_window_ctrl.sv
// rtl/conv1_window_ctrl.sv - frame sequencer and 3x3 window generator for conv1
module conv1_window_ctrl #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int CNT_W = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic pixel_in,
   input  logic valid_in,
   output logic ready_in,
   output logic pixel_0,
   output logic pixel_1,
   output logic pixel_2,
   output logic pixel_3,
   output logic pixel_4,
   output logic pixel_5,
   output logic pixel_6,
   output logic pixel_7,
   output logic pixel_8,
   output logic valid_in_buf,
   output logic busy,
   output logic frame_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] row, col;
   logic             linebuf0 [IMG_W];
   logic             linebuf1 [IMG_W];
   logic             accept;
   logic             last_px;

   assign accept  = valid_in & ready_in;
   assign last_px = (row == LAST_ROW) && (col == LAST_COL);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake/status outputs; RUN uses valid_in directly since ready_in is 1 there
   always_comb begin
      state_nxt  = state;
      ready_in   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            ready_in = 1'b1;
            busy     = 1'b1;
            if (valid_in && last_px) state_nxt = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (accept) begin
         if (col == LAST_COL) begin
            col <= '0;
            row <= (row == LAST_ROW) ? '0 : row + CNT_W'(1);
         end else begin
            col <= col + CNT_W'(1);
         end
      end
   end

   // Line buffers: linebuf0 holds the previous row, linebuf1 the one above it
   always_ff @(posedge clk) begin
      if (accept) begin
         linebuf1[col] <= linebuf0[col];
         linebuf0[col] <= pixel_in;
      end
   end

   // Window shift register; flagged only when the full 3x3 lies inside the current row span
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_in_buf <= 1'b0;
         pixel_0 <= 1'b0; pixel_1 <= 1'b0; pixel_2 <= 1'b0;
         pixel_3 <= 1'b0; pixel_4 <= 1'b0; pixel_5 <= 1'b0;
         pixel_6 <= 1'b0; pixel_7 <= 1'b0; pixel_8 <= 1'b0;
      end else begin
         valid_in_buf <= accept && (row >= TWO) && (col >= TWO);
         if (accept) begin
            pixel_0 <= pixel_1; pixel_1 <= pixel_2; pixel_2 <= linebuf1[col];
            pixel_3 <= pixel_4; pixel_4 <= pixel_5; pixel_5 <= linebuf0[col];
            pixel_6 <= pixel_7; pixel_7 <= pixel_8; pixel_8 <= pixel_in;
         end
      end
   end

endmodule

// File: doc/conv1_window_ctrl.md
Name: conv1_window_ctrl

Overview:
Frame sequencer and window generator for the first binary convolution layer. Accepts a raster-ordered 1-bit pixel stream under a valid/ready handshake and maintains two line buffers plus a 3x3 window. It drives the nine window pixels and valid_in_buf of the 8-channel XNOR/popcount conv1 stage for every fully-interior 3x3 window. It also tracks frame progress and signals frame completion to the top-level controller.

Parameters:
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in pixels (>=3)
CNT_W, 5, row/column counter width; must satisfy 2^CNT_W >= max(IMG_W, IMG_H)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  single-cycle frame start request
pixel_in  input  1  binary pixel, raster order (row 0 col 0 first)
valid_in  input  1  pixel_in valid
ready_in  output  1  block accepts a pixel this cycle
pixel_0..pixel_8  output  1 each  3x3 window, row-major; pixel_0 = img[r-2][c-2], pixel_4 = img[r-1][c-1], pixel_8 = img[r][c]
valid_in_buf  output  1  window valid, one cycle per window
busy  output  1  frame in progress
frame_done  output  1  single-cycle pulse at frame end

Behaviour:
- Reset (async, rst_n=0): state IDLE; row=col=0; ready_in, busy, valid_in_buf, frame_done = 0; pixel_0..8 = 0. Line-buffer storage needs no reset. Windows are only flagged after a full fill.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready_in=0, busy=0. start=1 moves to RUN next cycle. A valid_in in the same cycle as start is not accepted.
  - RUN: ready_in=1, busy=1. Accept = valid_in & ready_in. On the accept of pixel (IMG_H-1, IMG_W-1), move to DONE.
  - DONE: lasts one cycle. ready_in=0, busy=1, frame_done=1. Then returns to IDLE.
- start is ignored in RUN and DONE.
- Per accept:
  - Shift the window left by one column; the new right column is {linebuf1[col], linebuf0[col], pixel_in}, top to bottom.
  - Write linebuf1[col] <= linebuf0[col] and linebuf0[col] <= pixel_in.
  - Advance the counters: col wraps IMG_W-1 -> 0 and increments row; row wraps to 0 at frame end.
- No accept: window, counters and line buffers hold. valid_in_buf=0.
- Latency: pixel_0..8 and valid_in_buf are registered and appear the cycle after the accept of pixel (r,c). valid_in_buf=1 only when that pixel has r>=2 and c>=2.
- Row-boundary windows: windows spanning a row boundary (c<2) are never flagged, even though the window registers contain stale columns.
- Window count: exactly (IMG_H-2)*(IMG_W-2) windows per frame (676 at default).
- Frame end: frame_done rises in the same cycle as the last valid_in_buf.
- When valid_in_buf=0, pixel_0..8 hold their previous values (conv1 ignores them).
- No downstream backpressure: the conv1 stage consumes every valid_in_buf cycle.
- Reset mid-frame: all state is cleared immediately. The partial frame is discarded and no frame_done is emitted. A new start is required.
- Counter arithmetic: unsigned CNT_W-bit. Comparisons use r>=2 and c>=2 exactly; there is no padding.

Test Plan:
1. start, then 784 all-ones pixels with valid_in=1 continuously:
   - exactly 676 valid_in_buf pulses, all pixel_0..8=1;
   - first pulse the cycle after accept #59 (row 2, col 2);
   - frame_done 1 cycle after accept #784, coincident with the 676th pulse; busy drops the cycle after.
2. Checkerboard img[r][c]=(r+c)%2, continuous:
   - first window pixel_0..8 = 0,1,0,1,0,1,0,1,0; second window = 1,0,1,0,1,0,1,0,1;
   - no pulse after accepts at col 0 or 1 of any row.
3. Single 1 at (10,10), all other pixels 0:
   - exactly 9 windows contain a 1;
   - the window ending at (10,10) has only pixel_8=1, and the window ending at (12,12) has only pixel_0=1.
4. valid_in toggled pseudo-randomly at 50%:
   - same 676 windows and contents as scenario 1 or 2;
   - valid_in_buf never high in a cycle following a non-accept cycle;
   - ready_in stays 1 throughout RUN.
5. Reset asserted asynchronously after 300 accepts:
   - outputs 0 immediately, with no frame_done;
   - after release, start plus a full checkerboard frame yields the scenario 2 results exactly.
6. Further start pulses during RUN are ignored, with no counter change. start plus valid_in in the IDLE cycle: the pixel is not accepted and ready_in rises the next cycle. Back-to-back frames, with start in the cycle after DONE, both produce 676 windows.
